// File: rtl/mod_reduction.sv
// Sequential modular reducer r = a mod p using restoring shift-subtract, one dividend bit per clock.
// Optional macro MOD_REDUCTION_SHORTCUT_EN: operands already below p finish on the start edge.
module mod_reduction #(
  parameter int unsigned       width = 128,
  parameter logic [width-1:0]  p     = 128'd37
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2*width-1:0]   a,
  output logic                 done,
  output logic [width-1:0]     r
);

  localparam int unsigned CW = $clog2(2*width+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*width-1:0]   shreg_q, shreg_d;
  logic [width:0]       rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [width-1:0]     r_q, r_d;

  logic [width:0]       t;
  logic [width:0]       p_ext;
  logic [width:0]       t_red;
  logic                 unused_rem_msb;

  // rem stays below p, so its top bit is always clear and drops out of the shift.
  assign t              = {rem_q[width-1:0], shreg_q[2*width-1]};
  assign p_ext          = {1'b0, p};
  assign t_red          = (t >= p_ext) ? (t - p_ext) : t;
  assign unused_rem_msb = rem_q[width];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
`ifdef MOD_REDUCTION_SHORTCUT_EN
          if (a < {{width{1'b0}}, p}) begin
            r_d     = a[width-1:0];
            state_d = DONE;
          end else begin
            shreg_d = a;
            rem_d   = '0;
            cnt_d   = CW'(2*width);
            state_d = RUN;
          end
`else
          shreg_d = a;
          rem_d   = '0;
          cnt_d   = CW'(2*width);
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        shreg_d = shreg_q << 1;
        rem_d   = t_red;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          r_d     = t_red[width-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        // Holding enable high parks here; a new start needs enable to drop first.
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  assign done = (state_q == DONE);
  assign r    = r_q;

endmodule

// File: tb/tb_mod_reduction.sv
// Scoreboard bench for mod_reduction (width=128, p=37): stimulus pushes expected r, a monitor pops on each done rise.
module tb_mod_reduction;

  localparam int W = 128;

  logic           clk;
  logic           reset;
  logic           enable;
  logic [2*W-1:0] a;
  logic           done;
  logic [W-1:0]   r;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         prev_done;

  mod_reduction #(.width(W), .p(128'd37)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .a      (a),
    .done   (done),
    .r      (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares r against the scoreboard on every rising done.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got r=%0d expected no result", r);
        end else begin
          check("result_r", r, exp_q.pop_front());
        end
      end
      prev_done = done;
    end
  end

  // Expected number of edges from start edge (inclusive) until done is seen.
  function automatic int exp_lat(input logic [2*W-1:0] av);
`ifdef MOD_REDUCTION_SHORTCUT_EN
    if (av < 256'd37) return 1;
`endif
    return 257;
  endfunction

  // Start one reduction, measure latency, verify hold-without-restart, then re-arm.
  task automatic run_op(input string name, input logic [2*W-1:0] av, input logic [W-1:0] er,
                        input int chg_at, input logic [2*W-1:0] av_chg);
    int n;
    @(negedge clk);
    a      = av;
    enable = 1'b1;
    exp_q.push_back(er);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (n == chg_at) a = av_chg;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done after %0d edges expected done", name, n);
    end else begin
      check({name, "_latency"}, W'(n), W'(exp_lat(av)));
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_done"}, W'(done), W'(1));
    end
    check({name, "_hold_r"}, r, er);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_drop_done"}, W'(done), W'(0));
    check({name, "_idle_r"}, r, er);
  endtask

  initial begin
    logic [2*W-1:0] all_ones;
    int n;
    all_ones = '1;
    reset  = 1'b1;
    enable = 1'b0;
    a      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", W'(done), W'(0));
    check("reset_r", r, '0);
    @(negedge clk);
    reset = 1'b0;

    run_op("a382", 256'd382, 128'd12, 0, '0);
    run_op("a36", 256'd36, 128'd36, 0, '0);
    run_op("a0", 256'd0, 128'd0, 0, '0);
    run_op("a37", 256'd37, 128'd0, 0, '0);
    run_op("a_max", all_ones, 128'd15, 0, '0);

    // Reset in the middle of RUN: previous r (15) must clear immediately.
    @(negedge clk);
    a      = 256'd382;
    enable = 1'b1;
    for (n = 0; n < 100; n++) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrun_reset_done", W'(done), W'(0));
    check("midrun_reset_r", r, '0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("a100", 256'd100, 128'd26, 0, '0);
    run_op("a74", 256'd74, 128'd0, 0, '0);
    // a changes mid-RUN to 40 (40 mod 37 = 3); captured 382 must win.
    run_op("a_chg", 256'd382, 128'd12, 20, 256'd40);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
